mem_bus_arbiter: RTL

- Shares one single-port memory bus between the CPU instruction-fetch port and data port; replaces the dual-port Harvard memory with a unified von Neumann memory.
- Sits between the MIPS core and the memory bus. Sequences each access with a req/done handshake against a downstream waitrequest.
- Generates the core stall signal.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch and data ports.
// Accesses are serialised: IDLE -> X_REQ (strobe until accepted or timed out) -> X_RESP (done pulse) -> IDLE.
module mem_bus_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] m_addr,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_waitrequest,
    input  logic [31:0] m_rdata,
    output logic        stall,
    output logic        bus_error
);

    localparam int CW = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate on requests
    // I_REQ  | instruction read strobe on the bus
    // I_RESP | instruction data returned, i_done pulse
    // D_REQ  | data read/write strobe on the bus
    // D_RESP | data access complete, d_done pulse
    typedef enum logic [2:0] {
        IDLE,
        I_REQ,
        I_RESP,
        D_REQ,
        D_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;
    logic            lat_wr;
    logic            lat_abort;
    logic [CW-1:0]   wait_cnt;
    logic            last_data;
    logic [31:0]     i_hold;
    logic [31:0]     d_hold;
    logic            dreq;
    logic            grant_i;
    logic            grant_d;
    logic            in_req;
    logic            timeout;
    logic [31:0]     i_resp_data;
    logic [31:0]     d_resp_data;

    assign dreq   = d_rd | d_wr;
    assign in_req = (state == I_REQ) || (state == D_REQ);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && i_req) begin
                    // Round-robin hands the tie to whichever port did not win last time.
                    grant_d = (ARB_MODE == 0) || !last_data;
                    grant_i = !grant_d;
                end else begin
                    grant_d = dreq;
                    grant_i = i_req;
                end
                if (grant_d) begin
                    state_nxt = D_REQ;
                end else if (grant_i) begin
                    state_nxt = I_REQ;
                end
            end
            I_REQ, D_REQ: begin
                if (!m_waitrequest) begin
                    state_nxt = (state == I_REQ) ? I_RESP : D_RESP;
                end else if ((WAIT_LIMIT != 0) && (wait_cnt == WAIT_LAST)) begin
                    timeout   = 1'b1;
                    state_nxt = (state == I_REQ) ? I_RESP : D_RESP;
                end
            end
            I_RESP, D_RESP: state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_be    = 4'h0;
        m_read  = 1'b0;
        m_write = 1'b0;
        if (in_req) begin
            m_addr  = lat_addr;
            m_wdata = lat_wdata;
            m_be    = lat_be;
            m_read  = !lat_wr;
            m_write = lat_wr;
        end
    end

    assign i_done      = (state == I_RESP);
    assign d_done      = (state == D_RESP);
    assign i_resp_data = lat_abort ? 32'h0 : m_rdata;
    assign d_resp_data = (lat_abort || lat_wr) ? 32'h0 : m_rdata;
    assign i_rdata     = i_done ? i_resp_data : i_hold;
    assign d_rdata     = d_done ? d_resp_data : d_hold;
    assign stall       = (i_req & ~i_done) | (dreq & ~d_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            lat_wr    <= 1'b0;
            lat_abort <= 1'b0;
            wait_cnt  <= '0;
            last_data <= 1'b1;
            bus_error <= 1'b0;
            i_hold    <= 32'h0;
            d_hold    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                lat_addr  <= i_addr;
                lat_wdata <= 32'h0;
                lat_be    <= 4'hF;
                lat_wr    <= 1'b0;
                lat_abort <= 1'b0;
                wait_cnt  <= '0;
                last_data <= 1'b0;
            end else if (grant_d) begin
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_be    <= d_be;
                lat_wr    <= d_wr;
                lat_abort <= 1'b0;
                wait_cnt  <= '0;
                last_data <= 1'b1;
            end
            if (in_req && m_waitrequest) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (timeout) begin
                lat_abort <= 1'b1;
                bus_error <= 1'b1;
            end
            if (i_done) begin
                i_hold <= i_resp_data;
            end
            if (d_done) begin
                d_hold <= d_resp_data;
            end
        end
    end

endmodule
